// File: rtl/proc_pipe_ctrl.sv
// proc_pipe_ctrl
// Sequences NUM_STAGES chained processing units over start/ready handshakes.
// Each stage holds at most one packet; packets retire strictly in order.
// Provides per-stage drop, a watchdog with abort, a pause hook for safe
// table reconfiguration and statistics counters.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_empty_i          input header FIFO empty
//   in_rd_o             one-cycle pop of the input FIFO on admission
//   out_full_i          output FIFO full
//   out_wr_o, out_tag_o push of a retired packet and its tag
//   stg_start_o         per-stage start pulse
//   stg_tag_o           tag held by each stage, stage i at [i*TAG_W +: TAG_W]
//   stg_ready_i         per-stage done (only honoured while BUSY)
//   stg_drop_i          qualifies stg_ready_i: discard the packet
//   stg_abort_o         one-cycle abort on watchdog expiry
//   drop_o              one-cycle pulse per stage discarding its packet
//   cfg_pause_i         block admission of new packets
//   idle_o              all stages IDLE
//   pkt_cnt_o           packets retired
//   drop_cnt_o          packets dropped, including timeouts
//   timeout_cnt_o       watchdog expiries
//
// Per-stage FSM:
//   state | meaning
//   IDLE  | no packet held; may accept one
//   START | start pulse issued, watchdog cleared
//   BUSY  | unit processing; waiting for ready or watchdog expiry
//   HOLD  | result held; waiting to hand on, push out, or discard

module proc_pipe_ctrl #(
  parameter int NUM_STAGES = 3,
  parameter int TAG_W      = 4,
  parameter int TIMEOUT    = 256,
  parameter int CNT_W      = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_empty_i,
  output logic                        in_rd_o,
  input  logic                        out_full_i,
  output logic                        out_wr_o,
  output logic [TAG_W-1:0]            out_tag_o,
  output logic [NUM_STAGES-1:0]       stg_start_o,
  output logic [NUM_STAGES*TAG_W-1:0] stg_tag_o,
  input  logic [NUM_STAGES-1:0]       stg_ready_i,
  input  logic [NUM_STAGES-1:0]       stg_drop_i,
  output logic [NUM_STAGES-1:0]       stg_abort_o,
  output logic [NUM_STAGES-1:0]       drop_o,
  input  logic                        cfg_pause_i,
  output logic                        idle_o,
  output logic [CNT_W-1:0]            pkt_cnt_o,
  output logic [CNT_W-1:0]            drop_cnt_o,
  output logic [CNT_W-1:0]            timeout_cnt_o
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_HOLD  = 2'd3
  } stage_state_t;

  stage_state_t          state_q [NUM_STAGES];
  stage_state_t          state_d [NUM_STAGES];
  logic [TMR_W-1:0]      timer_q [NUM_STAGES];
  logic [TMR_W-1:0]      timer_d [NUM_STAGES];
  logic [TAG_W-1:0]      tag_q   [NUM_STAGES];
  logic [TAG_W-1:0]      tag_d   [NUM_STAGES];
  logic [TAG_W-1:0]      src_tag [NUM_STAGES];
  logic [NUM_STAGES-1:0] dflag_q, dflag_d;
  logic [NUM_STAGES-1:0] start_q, start_d;
  logic [NUM_STAGES-1:0] abort_q, abort_d;
  logic [NUM_STAGES-1:0] drop_q, drop_d;
  logic [NUM_STAGES-1:0] fwd, sink_free;
  logic [TAG_W-1:0]      next_tag_q, next_tag_d;
  logic [TAG_W-1:0]      out_tag_q, out_tag_d;
  logic                  rd_q, rd_d, wr_q, wr_d, idle_q, idle_d;
  logic                  admit, retire;
  logic [CNT_W-1:0]      pkt_cnt_q, pkt_cnt_d;
  logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0]      to_cnt_q, to_cnt_d;

  // Handshake conditions between neighbours, all from registered state so a
  // stage emptying this cycle is only seen as free next cycle (one bubble).
  always_comb begin
    fwd       = '0;
    sink_free = '0;
    admit     = !in_empty_i && !cfg_pause_i && (state_q[0] == S_IDLE);
    retire    = (state_q[NUM_STAGES-1] == S_HOLD) && !dflag_q[NUM_STAGES-1] && !out_full_i;
    fwd[0]     = admit;
    src_tag[0] = next_tag_q;
    for (int i = 1; i < NUM_STAGES; i++) begin
      fwd[i]     = (state_q[i-1] == S_HOLD) && !dflag_q[i-1];
      src_tag[i] = tag_q[i-1];
    end
    for (int i = 0; i < NUM_STAGES - 1; i++) begin
      sink_free[i] = (state_q[i+1] == S_IDLE);
    end
    sink_free[NUM_STAGES-1] = !out_full_i;
  end

  always_comb begin
    start_d = '0;
    abort_d = '0;
    drop_d  = '0;
    dflag_d = dflag_q;
    for (int i = 0; i < NUM_STAGES; i++) begin
      state_d[i] = state_q[i];
      timer_d[i] = timer_q[i];
      tag_d[i]   = tag_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (fwd[i]) begin
            state_d[i] = S_START;
            tag_d[i]   = src_tag[i];
            timer_d[i] = '0;
            start_d[i] = 1'b1;
          end
        end
        S_START: begin
          // The watchdog counts cycles since the start pulse, so expiry
          // lands exactly TIMEOUT cycles after it.
          state_d[i] = S_BUSY;
          timer_d[i] = TMR_W'(1);
        end
        S_BUSY: begin
          if (stg_ready_i[i]) begin
            state_d[i] = S_HOLD;
            dflag_d[i] = stg_drop_i[i];
          end else if (timer_q[i] == TMR_LAST) begin
            state_d[i] = S_HOLD;
            dflag_d[i] = 1'b1;
            abort_d[i] = 1'b1;
          end else begin
            timer_d[i] = timer_q[i] + TMR_W'(1);
          end
        end
        S_HOLD: begin
          if (dflag_q[i]) begin
            state_d[i] = S_IDLE;
            drop_d[i]  = 1'b1;
          end else if (sink_free[i]) begin
            state_d[i] = S_IDLE;
          end
        end
        default: state_d[i] = S_IDLE;
      endcase
    end

    rd_d       = admit;
    wr_d       = retire;
    out_tag_d  = retire ? tag_q[NUM_STAGES-1] : out_tag_q;
    next_tag_d = admit ? next_tag_q + TAG_W'(1) : next_tag_q;

    idle_d     = 1'b1;
    pkt_cnt_d  = pkt_cnt_q + CNT_W'(retire);
    drop_cnt_d = drop_cnt_q;
    to_cnt_d   = to_cnt_q;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (state_d[i] != S_IDLE) idle_d = 1'b0;
      drop_cnt_d = drop_cnt_d + CNT_W'(drop_d[i]);
      to_cnt_d   = to_cnt_d + CNT_W'(abort_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        state_q[i] <= S_IDLE;
        timer_q[i] <= '0;
        tag_q[i]   <= '0;
      end
      dflag_q    <= '0;
      start_q    <= '0;
      abort_q    <= '0;
      drop_q     <= '0;
      next_tag_q <= '0;
      out_tag_q  <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      idle_q     <= 1'b1;
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
      to_cnt_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        state_q[i] <= state_d[i];
        timer_q[i] <= timer_d[i];
        tag_q[i]   <= tag_d[i];
      end
      dflag_q    <= dflag_d;
      start_q    <= start_d;
      abort_q    <= abort_d;
      drop_q     <= drop_d;
      next_tag_q <= next_tag_d;
      out_tag_q  <= out_tag_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      idle_q     <= idle_d;
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  always_comb begin
    stg_tag_o = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      stg_tag_o[i*TAG_W +: TAG_W] = tag_q[i];
    end
  end

  assign in_rd_o       = rd_q;
  assign out_wr_o      = wr_q;
  assign out_tag_o     = out_tag_q;
  assign stg_start_o   = start_q;
  assign stg_abort_o   = abort_q;
  assign drop_o        = drop_q;
  assign idle_o        = idle_q;
  assign pkt_cnt_o     = pkt_cnt_q;
  assign drop_cnt_o    = drop_cnt_q;
  assign timeout_cnt_o = to_cnt_q;

endmodule

// File: tb/tb_proc_pipe_ctrl.sv
`timescale 1ns/1ps
// Bench for proc_pipe_ctrl. The bench plays the input FIFO, the stage units
// and the output FIFO. A packet-level model (per-stage occupancy, start
// time, planned ready time) predicts every cycle's pulses, tags and counters.

module tb_proc_pipe_ctrl;
  localparam int N  = 3;
  localparam int TW = 2;
  localparam int TO = 8;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_empty_i, in_rd_o, out_full_i, out_wr_o, cfg_pause_i, idle_o;
  logic [TW-1:0] out_tag_o;
  logic [N-1:0]  stg_start_o, stg_ready_i, stg_drop_i, stg_abort_o, drop_o;
  logic [N*TW-1:0] stg_tag_o;
  logic [CW-1:0] pkt_cnt_o, drop_cnt_o, timeout_cnt_o;

  proc_pipe_ctrl #(.NUM_STAGES(N), .TAG_W(TW), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_empty_i(in_empty_i), .in_rd_o(in_rd_o),
    .out_full_i(out_full_i), .out_wr_o(out_wr_o), .out_tag_o(out_tag_o),
    .stg_start_o(stg_start_o), .stg_tag_o(stg_tag_o),
    .stg_ready_i(stg_ready_i), .stg_drop_i(stg_drop_i),
    .stg_abort_o(stg_abort_o), .drop_o(drop_o),
    .cfg_pause_i(cfg_pause_i), .idle_o(idle_o),
    .pkt_cnt_o(pkt_cnt_o), .drop_cnt_o(drop_cnt_o), .timeout_cnt_o(timeout_cnt_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", name, got, exp);
    end
  endtask

  // model state (values describe the most recently processed cycle)
  int cyc = 0;
  bit occ     [N];
  int st_at   [N];
  int rdy_at  [N];
  int drop_at [N];
  bit never_m [N];
  bit dreq_m  [N];
  int tag_m   [N];
  int next_tag_m = 0;
  int pkt_m = 0, drop_m = 0, to_m = 0;
  int fifo_cnt = 0;
  bit prev_rst = 1'b1, prev_empty = 1'b1, prev_pause = 1'b0, prev_full = 1'b0;
  int obs_rd = 0, obs_wr = 0;

  // knobs
  int fixed_lat = 0, drop_pct = 0, never_pct = 0, target = -1;
  int full_pct = 0, pause_pct = 0, bubble_pct = 0, noise_pct = 0;
  bit force_full = 1'b0, force_pause = 1'b0, rst_req = 1'b1;

  function automatic bit any_occ();
    for (int i = 0; i < N; i++) if (occ[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic plan_response(input int i);
    int lat;
    bit hit;
    hit        = (target < 0) || (target == i);
    never_m[i] = hit && ($urandom_range(0, 99) < never_pct);
    lat        = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(1, TO - 1));
    rdy_at[i]  = cyc + lat;
    dreq_m[i]  = !never_m[i] && hit && ($urandom_range(0, 99) < drop_pct);
    if (never_m[i])     drop_at[i] = cyc + TO + 1;
    else if (dreq_m[i]) drop_at[i] = rdy_at[i] + 2;
    else                drop_at[i] = -1;
  endtask

  task automatic step();
    bit [N-1:0] e_start, e_abort, e_drop, take, rdy, drp;
    bit [N:0]   tmp;
    bit         hold_ok [N];
    bit         e_rd, e_wr, busy;
    int         e_otag;
    @(negedge clk);
    cyc++;
    obs_rd += int'(in_rd_o);
    obs_wr += int'(out_wr_o);
    if (prev_rst) begin
      for (int i = 0; i < N; i++) occ[i] = 1'b0;
      next_tag_m = 0; pkt_m = 0; drop_m = 0; to_m = 0;
      check_val("rst_rd", in_rd_o, 0);
      check_val("rst_wr", out_wr_o, 0);
      check_val("rst_start", stg_start_o, 0);
      check_val("rst_abort", stg_abort_o, 0);
      check_val("rst_drop", drop_o, 0);
      check_val("rst_idle", idle_o, 1);
      check_val("rst_stg_tag", stg_tag_o, 0);
      check_val("rst_out_tag", out_tag_o, 0);
      check_val("rst_cnts", {pkt_cnt_o | drop_cnt_o | timeout_cnt_o}, 0);
    end else begin
      for (int i = 0; i < N; i++)
        hold_ok[i] = occ[i] && !never_m[i] && !dreq_m[i] && (cyc >= rdy_at[i] + 2);
      e_rd       = !prev_empty && !prev_pause && !occ[0];
      e_start[0] = e_rd;
      for (int i = 1; i < N; i++) e_start[i] = hold_ok[i-1] && !occ[i];
      e_wr = hold_ok[N-1] && !prev_full;
      for (int i = 0; i < N; i++) begin
        e_abort[i] = occ[i] && never_m[i] && (cyc == st_at[i] + TO);
        e_drop[i]  = occ[i] && (cyc == drop_at[i]);
      end
      e_otag = tag_m[N-1];
      tmp  = {e_wr, e_start};
      take = tmp[N:1];
      for (int i = 0; i < N; i++) if (e_drop[i] || take[i]) occ[i] = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
        if (e_start[i]) begin
          occ[i]   = 1'b1;
          st_at[i] = cyc;
          if (i == 0) begin
            tag_m[0]   = next_tag_m;
            next_tag_m = (next_tag_m + 1) % (1 << TW);
          end else begin
            tag_m[i] = tag_m[i-1];
          end
          plan_response(i);
        end
      end
      if (e_rd) fifo_cnt--;
      pkt_m  += int'(e_wr);
      drop_m += $countones(e_drop);
      to_m   += $countones(e_abort);

      check_val("in_rd", in_rd_o, e_rd);
      check_val("start", stg_start_o, e_start);
      check_val("out_wr", out_wr_o, e_wr);
      check_val("abort", stg_abort_o, e_abort);
      check_val("drop", drop_o, e_drop);
      check_val("idle", idle_o, !any_occ());
      check_val("pkt_cnt", pkt_cnt_o, pkt_m);
      check_val("drop_cnt", drop_cnt_o, drop_m);
      check_val("timeout_cnt", timeout_cnt_o, to_m);
      for (int i = 0; i < N; i++)
        if (e_start[i]) check_val($sformatf("stg_tag%0d", i), stg_tag_o[i*TW +: TW], tag_m[i]);
      if (e_wr) check_val("out_tag", out_tag_o, e_otag);
    end

    // inputs for this cycle
    for (int i = 0; i < N; i++) begin
      busy = occ[i] && (cyc > st_at[i]) &&
             (never_m[i] ? (cyc <= st_at[i] + TO - 1) : (cyc <= rdy_at[i]));
      if (busy) begin
        rdy[i] = !never_m[i] && (cyc == rdy_at[i]);
        drp[i] = rdy[i] ? dreq_m[i] : 1'($urandom_range(0, 1));
      end else begin
        rdy[i] = ($urandom_range(0, 99) < noise_pct);
        drp[i] = 1'($urandom_range(0, 1));
      end
    end
    rst         = rst_req;
    in_empty_i  = (fifo_cnt == 0) || ($urandom_range(0, 99) < bubble_pct);
    cfg_pause_i = force_pause || ($urandom_range(0, 99) < pause_pct);
    out_full_i  = force_full || ($urandom_range(0, 99) < full_pct);
    stg_ready_i = rdy;
    stg_drop_i  = drp;
    prev_rst    = rst;
    prev_empty  = in_empty_i;
    prev_pause  = cfg_pause_i;
    prev_full   = out_full_i;
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while ((fifo_cnt > 0 || any_occ()) && k < budget) begin
      step();
      k++;
    end
    check_val(name, (fifo_cnt == 0) && !any_occ(), 1);
    repeat (2) step();
  endtask

  initial begin
    int k;
    rst = 1'b1; in_empty_i = 1'b1; cfg_pause_i = 1'b0; out_full_i = 1'b0;
    stg_ready_i = '0; stg_drop_i = '0;
    rst_req = 1'b1;
    repeat (3) step();
    rst_req = 1'b0;
    step();

    // single packet, 2-cycle units
    fixed_lat = 2; fifo_cnt = 1;
    drain("drain_single", 200);

    // back-to-back packets, tags wrap past 3
    fifo_cnt = 6;
    drain("drain_b2b", 400);

    // drops on stage 1 with random latencies (ready on the expiry cycle included)
    fixed_lat = 0; drop_pct = 50; target = 1; fifo_cnt = 6;
    drain("drain_drop", 600);

    // stage 2 sometimes never ready -> watchdog
    drop_pct = 0; never_pct = 40; target = 2; fifo_cnt = 6;
    drain("drain_timeout", 800);

    // output backpressure for 20 cycles with 4 packets queued
    never_pct = 0; target = -1; fixed_lat = 2;
    force_full = 1'b1; fifo_cnt = 4; obs_rd = 0; obs_wr = 0;
    repeat (20) step();
    check_val("full_rd_count", obs_rd, 3);
    check_val("full_wr_count", obs_wr, 0);
    force_full = 1'b0;
    drain("drain_full", 400);

    // pause with two packets in flight
    fixed_lat = 3; fifo_cnt = 4; obs_rd = 0; k = 0;
    while (obs_rd < 2 && k < 60) begin step(); k++; end
    check_val("pause_admits", obs_rd, 2);
    force_pause = 1'b1; obs_rd = 0;
    repeat (40) step();
    check_val("pause_rd_count", obs_rd, 0);
    check_val("pause_idle", idle_o, 1);
    force_pause = 1'b0;
    drain("drain_pause", 400);

    // random traffic
    fixed_lat = 0; drop_pct = 15; never_pct = 10; target = -1;
    full_pct = 20; pause_pct = 20; bubble_pct = 20; noise_pct = 30;
    fifo_cnt = 40;
    drain("drain_random", 4000);

    // reset in the middle of traffic: no drop/abort pulses, everything cleared
    fifo_cnt = 3;
    repeat (12) step();
    rst_req = 1'b1; fifo_cnt = 0;
    step();
    rst_req = 1'b0;
    repeat (3) step();
    fifo_cnt = 5;
    drain("drain_after_rst", 2000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
